pipelined_control_decoder: RTL and testbench

//  Registered, back-pressured successor to the combinational decoder. Accepts one MIPS instruction
//  per valid/ready handshake and presents its full control word one cycle later. Decodes all MIPS-I

---
 rtl/pipelined_control_decoder.sv | 252 +++++++++++++++++++++++++
 tb/tb_pipelined_control_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_decoder.sv
// Registered MIPS-I control decoder with valid/ready handshake and HI/LO hazard stalling.
// Optional macro CONTROL_ILLEGAL_TRAP_EN enables the sticky illegal_instruction flag.
module pipelined_control_decoder #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        instr_ready,
    output logic        ctrl_valid,
    input  logic        ctrl_ready,
    output logic        register_write,
    output logic        memory_to_register,
    output logic        memory_write,
    output logic [1:0]  memory_size,
    output logic        memory_sign_extend,
    output logic [1:0]  ALU_src_B,
    output logic [1:0]  register_destination,
    output logic        branch,
    output logic        hi_lo_register_write,
    output logic [5:0]  ALU_function,
    output logic        program_counter_multiplexer_jump,
    output logic        j_instruction,
    output logic        muldiv_busy,
    output logic        illegal_instruction
);

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);
    localparam logic [5:0] ALU_PASS  = 6'b111111;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;

    typedef struct packed {
        logic       register_write;
        logic       memory_to_register;
        logic       memory_write;
        logic [1:0] memory_size;
        logic       memory_sign_extend;
        logic [1:0] alu_src_b;
        logic [1:0] register_destination;
        logic       branch;
        logic       hi_lo_write;
        logic [5:0] alu_function;
        logic       pc_jump;
        logic       j_instruction;
    } ctrl_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    ctrl_t      dec;
    ctrl_t      word_p0;
    logic       legal;
    logic       mult_start;
    logic       div_start;
    logic       hilo_user;
    logic [5:0] muldiv_count;
    logic       hazard;
    logic       accept;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rt     = instruction[20:16];

    always_comb begin
        dec        = '0;
        legal      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        hilo_user  = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        legal              = 1'b1;
                        dec.register_write = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        legal              = 1'b1;
                        dec.register_write = 1'b1;
                        hilo_user          = 1'b1;
                    end
                    6'h11, 6'h13: begin
                        legal           = 1'b1;
                        dec.hi_lo_write = 1'b1;
                        hilo_user       = 1'b1;
                    end
                    6'h18, 6'h19: begin
                        legal           = 1'b1;
                        dec.hi_lo_write = 1'b1;
                        hilo_user       = 1'b1;
                        mult_start      = 1'b1;
                    end
                    6'h1A, 6'h1B: begin
                        legal           = 1'b1;
                        dec.hi_lo_write = 1'b1;
                        hilo_user       = 1'b1;
                        div_start       = 1'b1;
                    end
                    6'h08: begin
                        legal       = 1'b1;
                        dec.pc_jump = 1'b1;
                    end
                    6'h09: begin
                        legal              = 1'b1;
                        dec.pc_jump        = 1'b1;
                        dec.register_write = 1'b1;
                    end
                    6'h0C, 6'h0D: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    dec.register_destination = 2'd1;
                    dec.alu_function         = funct;
                end
            end
            6'h01: begin
                // rt selects BLTZ/BGEZ and their linking variants
                if (rt[3:1] == 3'b000) begin
                    legal            = 1'b1;
                    dec.branch       = 1'b1;
                    dec.alu_src_b    = 2'd2;
                    dec.alu_function = ALU_PASS;
                    if (rt[4]) begin
                        dec.register_write       = 1'b1;
                        dec.register_destination = 2'd2;
                    end
                end
            end
            6'h02: begin
                legal             = 1'b1;
                dec.j_instruction = 1'b1;
            end
            6'h03: begin
                legal                    = 1'b1;
                dec.j_instruction        = 1'b1;
                dec.register_write       = 1'b1;
                dec.register_destination = 2'd2;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                legal            = 1'b1;
                dec.branch       = 1'b1;
                dec.alu_function = ALU_PASS;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                legal              = 1'b1;
                dec.register_write = 1'b1;
                dec.alu_src_b      = (opcode inside {6'h0C, 6'h0D, 6'h0E}) ? 2'd3 : 2'd1;
                case (opcode)
                    6'h08:   dec.alu_function = 6'b100000;
                    6'h09:   dec.alu_function = 6'b100001;
                    6'h0A:   dec.alu_function = 6'b101010;
                    6'h0B:   dec.alu_function = 6'b101011;
                    6'h0C:   dec.alu_function = 6'b100100;
                    6'h0D:   dec.alu_function = 6'b100101;
                    6'h0E:   dec.alu_function = 6'b100110;
                    default: dec.alu_function = ALU_PASS;
                endcase
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
                legal                  = 1'b1;
                dec.register_write     = 1'b1;
                dec.memory_to_register = 1'b1;
                dec.alu_src_b          = 2'd1;
                dec.alu_function       = ALU_ADDU;
                dec.memory_sign_extend = (opcode == 6'h20) || (opcode == 6'h21);
                case (opcode)
                    6'h20, 6'h24: dec.memory_size = 2'd0;
                    6'h21, 6'h25: dec.memory_size = 2'd1;
                    default:      dec.memory_size = 2'd2;
                endcase
            end
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
                legal            = 1'b1;
                dec.memory_write = 1'b1;
                dec.alu_src_b    = 2'd1;
                dec.alu_function = ALU_ADDU;
                case (opcode)
                    6'h28:   dec.memory_size = 2'd0;
                    6'h29:   dec.memory_size = 2'd1;
                    default: dec.memory_size = 2'd2;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Hazard uses the pre-decrement count, so the stalled instruction enters the cycle after it hits zero.
    assign hazard      = (muldiv_count != 6'd0) && hilo_user;
    assign instr_ready = (!ctrl_valid || ctrl_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;
    assign muldiv_busy = (muldiv_count != 6'd0);

    // stage p0: registered control word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_valid   <= 1'b0;
            word_p0      <= '0;
            muldiv_count <= 6'd0;
        end else begin
            if (accept) begin
                ctrl_valid <= 1'b1;
                word_p0    <= dec;
            end else if (ctrl_ready) begin
                ctrl_valid <= 1'b0;
                word_p0    <= '0;
            end
            if (accept && mult_start) begin
                muldiv_count <= MULT_LOAD;
            end else if (accept && div_start) begin
                muldiv_count <= DIV_LOAD;
            end else if (muldiv_count != 6'd0) begin
                muldiv_count <= muldiv_count - 6'd1;
            end
        end
    end

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic unused_fields;
    assign unused_fields = ^{instruction[25:21], instruction[15:6]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_instruction <= 1'b0;
        end else if (accept && !legal) begin
            illegal_instruction <= 1'b1;
        end
    end
`else
    logic unused_fields;
    assign unused_fields       = ^{instruction[25:21], instruction[15:6], legal};
    assign illegal_instruction = 1'b0;
`endif

    assign register_write                   = word_p0.register_write;
    assign memory_to_register               = word_p0.memory_to_register;
    assign memory_write                     = word_p0.memory_write;
    assign memory_size                      = word_p0.memory_size;
    assign memory_sign_extend               = word_p0.memory_sign_extend;
    assign ALU_src_B                        = word_p0.alu_src_b;
    assign register_destination             = word_p0.register_destination;
    assign branch                           = word_p0.branch;
    assign hi_lo_register_write             = word_p0.hi_lo_write;
    assign ALU_function                     = word_p0.alu_function;
    assign program_counter_multiplexer_jump = word_p0.pc_jump;
    assign j_instruction                    = word_p0.j_instruction;

endmodule

// File: tb/tb_pipelined_control_decoder.sv
// Directed bench for pipelined_control_decoder: scoreboard of expected control words plus
// handshake, hazard-stall, busy-window, sticky-illegal and reset checks.
module tb_pipelined_control_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        register_write;
    logic        memory_to_register;
    logic        memory_write;
    logic [1:0]  memory_size;
    logic        memory_sign_extend;
    logic [1:0]  ALU_src_B;
    logic [1:0]  register_destination;
    logic        branch;
    logic        hi_lo_register_write;
    logic [5:0]  ALU_function;
    logic        program_counter_multiplexer_jump;
    logic        j_instruction;
    logic        muldiv_busy;
    logic        illegal_instruction;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int taken    = 0;
    int busy_cnt = 0;
    logic [19:0] exp_q[$];

    pipelined_control_decoder #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instruction(instruction),
        .instr_ready(instr_ready), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .register_write(register_write), .memory_to_register(memory_to_register),
        .memory_write(memory_write), .memory_size(memory_size),
        .memory_sign_extend(memory_sign_extend), .ALU_src_B(ALU_src_B),
        .register_destination(register_destination), .branch(branch),
        .hi_lo_register_write(hi_lo_register_write), .ALU_function(ALU_function),
        .program_counter_multiplexer_jump(program_counter_multiplexer_jump),
        .j_instruction(j_instruction), .muldiv_busy(muldiv_busy),
        .illegal_instruction(illegal_instruction)
    );

    always #5 clk = ~clk;

    logic [19:0] obs_word;
    assign obs_word = {register_write, memory_to_register, memory_write, memory_size,
                       memory_sign_extend, ALU_src_B, register_destination, branch,
                       hi_lo_register_write, ALU_function, program_counter_multiplexer_jump,
                       j_instruction};

    function automatic logic [19:0] w(input logic rw, input logic m2r, input logic mw,
                                      input logic [1:0] sz, input logic sx, input logic [1:0] sb,
                                      input logic [1:0] dst, input logic br, input logic hl,
                                      input logic [5:0] alu, input logic pj, input logic j);
        return {rw, m2r, mw, sz, sx, sb, dst, br, hl, alu, pj, j};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction and hold it until accepted; returns the number of stalled cycles.
    task automatic send(input logic [31:0] ins, input logic [19:0] exp, output int stalls);
        int n = 0;
        instruction = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_budget", {31'd0, instr_ready}, 32'd1);
        exp_q.push_back(exp);
        pushed++;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        stalls = n;
    endtask

    // Scoreboard: every control word the execute stage takes is compared with the oldest expectation.
    always @(negedge clk) begin
        if (muldiv_busy) busy_cnt++;
        if (ctrl_valid && ctrl_ready) begin
            taken++;
            if (exp_q.size() == 0) begin
                chk("unexpected_ctrl_word", {12'd0, obs_word}, 32'hFFFFFFFF);
            end else begin
                chk("ctrl_word", {12'd0, obs_word}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int st;
        logic [19:0] w_lw;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'd0;
        ctrl_ready  = 1'b1;
        #12;
        chk("reset_ctrl_valid", {31'd0, ctrl_valid}, 32'd0);
        chk("reset_word", {12'd0, obs_word}, 32'd0);
        chk("reset_busy", {31'd0, muldiv_busy}, 32'd0);
        chk("reset_illegal", {31'd0, illegal_instruction}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Straight-line decode stream with the execute stage always ready
        send(32'h24220005, w(1,0,0,2'd0,0,2'd1,2'd0,0,0,6'b100001,0,0), st);
        chk("addiu_no_stall", st, 0);
        send(32'h0C000010, w(1,0,0,2'd0,0,2'd0,2'd2,0,0,6'b000000,0,1), st);
        send(32'h10220003, w(0,0,0,2'd0,0,2'd0,2'd0,1,0,6'b111111,0,0), st);
        send(32'h04310002, w(1,0,0,2'd0,0,2'd2,2'd2,1,0,6'b111111,0,0), st);
        send(32'h34220FF0, w(1,0,0,2'd0,0,2'd3,2'd0,0,0,6'b100101,0,0), st);
        send(32'h80220001, w(1,1,0,2'd0,1,2'd1,2'd0,0,0,6'b100001,0,0), st);
        send(32'hA4220002, w(0,0,1,2'd1,0,2'd1,2'd0,0,0,6'b100001,0,0), st);
        send(32'h03E00008, w(0,0,0,2'd0,0,2'd0,2'd1,0,0,6'b001000,1,0), st);
        @(negedge clk);
        chk("illegal_clear_on_legal", {31'd0, illegal_instruction}, 32'd0);
        @(posedge clk); #1;
        send(32'h00000001, 20'd0, st);
        @(negedge clk);
        chk("illegal_after_bad_funct", {31'd0, illegal_instruction}, {31'd0, TRAP});
        @(posedge clk); #1;

        // LW held by a stalled execute stage
        ctrl_ready = 1'b0;
        w_lw = w(1,1,0,2'd2,0,2'd1,2'd0,0,0,6'b100001,0,0);
        send(32'h8C220004, w_lw, st);
        instruction = 32'h00432021;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_instr_ready", {31'd0, instr_ready}, 32'd0);
            chk("held_ctrl_valid", {31'd0, ctrl_valid}, 32'd1);
            chk("held_word", {12'd0, obs_word}, {12'd0, w_lw});
        end
        @(posedge clk); #1;
        ctrl_ready = 1'b1;
        send(32'h00432021, w(1,0,0,2'd0,0,2'd0,2'd1,0,0,6'b100001,0,0), st);
        chk("addu_after_release", st, 0);

        // MULT then MFLO: four stall cycles
        send(32'h00430018, w(0,0,0,2'd0,0,2'd0,2'd1,0,1,6'b011000,0,0), st);
        send(32'h00002012, w(1,0,0,2'd0,0,2'd0,2'd1,0,0,6'b010010,0,0), st);
        chk("mflo_stall_cycles", st, 4);

        // DIV then independent ADDU: no stall, busy for 32 cycles
        busy_cnt = 0;
        send(32'h0043001A, w(0,0,0,2'd0,0,2'd0,2'd1,0,1,6'b011010,0,0), st);
        send(32'h00432021, w(1,0,0,2'd0,0,2'd0,2'd1,0,0,6'b100001,0,0), st);
        chk("addu_flows_during_div", st, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("div_busy_cycles", busy_cnt, 32);

        // Unknown opcode and stickiness
        send(32'hFC000000, 20'd0, st);
        send(32'h24220005, w(1,0,0,2'd0,0,2'd1,2'd0,0,0,6'b100001,0,0), st);
        @(negedge clk);
        chk("illegal_sticky", {31'd0, illegal_instruction}, {31'd0, TRAP});
        @(posedge clk); #1;

        // Reset in the middle of a MULT countdown
        send(32'h00430018, w(0,0,0,2'd0,0,2'd0,2'd1,0,1,6'b011000,0,0), st);
        #2;
        chk("busy_before_reset", {31'd0, muldiv_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, muldiv_busy}, 32'd0);
        chk("async_reset_valid", {31'd0, ctrl_valid}, 32'd0);
        chk("async_reset_word", {12'd0, obs_word}, 32'd0);
        chk("async_reset_illegal", {31'd0, illegal_instruction}, 32'd0);
        taken = taken + exp_q.size();
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(32'h00002012, w(1,0,0,2'd0,0,2'd0,2'd1,0,0,6'b010010,0,0), st);
        chk("mflo_after_reset_no_stall", st, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("taken_equals_pushed", taken, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
